pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   // Mul/div sequencing state: IDLE waits for a mul/div in EXE, BUSY holds the front end
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // Instruction word loaded into a flushed pipeline register
   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

   // Bundle of per-stage controls driven every cycle
   typedef struct packed {
      logic md_go;
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_exe_en;
      logic id_exe_flush;
      logic exe_mem_en;
      logic exe_mem_flush;
   } ctrl_t;

   // Free-running pipeline: everything advances, nothing squashed
   localparam ctrl_t CTRL_RUN = '{md_go: 1'b0, pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                  id_exe_en: 1'b1, id_exe_flush: 1'b0,
                                  exe_mem_en: 1'b1, exe_mem_flush: 1'b0};

   // Held in reset: nothing loads, every register is forced to a bubble
   localparam ctrl_t CTRL_RESET = '{md_go: 1'b0, pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                    id_exe_en: 1'b0, id_exe_flush: 1'b1,
                                    exe_mem_en: 1'b0, exe_mem_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EXE and the sources of the ID instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall decision in the sequencer.
module pipe_hazard_ctrl_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [ADDR_W-1:0] exe_dst_i,
   input  logic              exe_wen_i,
   input  logic              exe_is_load_i,
   output logic              load_use_o
);

   logic rs_hit;
   logic rt_hit;

   // Register 0 is hardwired, so a load targeting it never creates a dependency
   assign rs_hit     = id_uses_rs_i && (id_rs_i == exe_dst_i);
   assign rt_hit     = id_uses_rt_i && (id_rt_i == exe_dst_i);
   assign load_use_o = exe_is_load_i && exe_wen_i && (exe_dst_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stall, branch squash, mul/div start/hold/release, debug counters.
// Latency: controls are combinational from state and inputs (same cycle); counters update next edge.
// Backpressure: holds PC, IF/ID and ID/EXE while a load-use or mul/div is outstanding.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W        = REG_ADDR_W,
   parameter int CNT_W         = 32,
   parameter int MD_MAX_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] id_rs_i,
   input  logic [ADDR_W-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [ADDR_W-1:0] exe_dst_i,
   input  logic              exe_wen_i,
   input  logic              exe_is_load_i,
   input  logic              exe_is_md_i,
   input  logic              exe_br_taken_i,
   input  logic              md_done_i,
   output logic              md_go_o,
   output logic              pc_en_o,
   output logic              if_id_en_o,
   output logic              if_id_flush_o,
   output logic              id_exe_en_o,
   output logic              id_exe_flush_o,
   output logic              exe_mem_en_o,
   output logic              exe_mem_flush_o,
   output logic [CNT_W-1:0]  stall_cycles_o,
   output logic              md_timeout_o
);

   localparam int             WD_W    = $clog2(MD_MAX_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             md_timeout_q, md_timeout_d;
   logic             load_use;
   ctrl_t            ctrl;

   pipe_hazard_ctrl_hazard_detect #(
      .ADDR_W (ADDR_W)
   ) u_hazard_detect (
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_uses_rs_i  (id_uses_rs_i),
      .id_uses_rt_i  (id_uses_rt_i),
      .exe_dst_i     (exe_dst_i),
      .exe_wen_i     (exe_wen_i),
      .exe_is_load_i (exe_is_load_i),
      .load_use_o    (load_use)
   );

   // Next state and stage controls; mul/div outranks branch, branch outranks load-use
   always_comb begin
      ctrl         = CTRL_RUN;
      state_d      = state_q;
      wd_d         = wd_q;
      md_timeout_d = md_timeout_q;
      if (!rst_ni) begin
         // Reset is asynchronous, so the controls must show bubbles without waiting for an edge
         ctrl = CTRL_RESET;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (exe_is_md_i) begin
                  ctrl.md_go         = 1'b1;
                  ctrl.pc_en         = 1'b0;
                  ctrl.if_id_en      = 1'b0;
                  ctrl.id_exe_en     = 1'b0;
                  ctrl.exe_mem_flush = 1'b1;
                  state_d            = ST_BUSY;
                  wd_d               = '0;
               end else if (exe_br_taken_i) begin
                  // Dependent instruction is squashed anyway, so no load-use stall is needed
                  ctrl.if_id_flush  = 1'b1;
                  ctrl.id_exe_flush = 1'b1;
               end else if (load_use) begin
                  ctrl.pc_en        = 1'b0;
                  ctrl.if_id_en     = 1'b0;
                  ctrl.id_exe_flush = 1'b1;
               end
            end
            ST_BUSY: begin
               if (md_done_i || (wd_q == WD_LAST)) begin
                  // Release: run controls let EXE/MEM capture the result (or whatever is there)
                  state_d = ST_IDLE;
                  wd_d    = '0;
                  if (!md_done_i) begin
                     md_timeout_d = 1'b1;
                  end
               end else begin
                  ctrl.pc_en         = 1'b0;
                  ctrl.if_id_en      = 1'b0;
                  ctrl.id_exe_en     = 1'b0;
                  ctrl.exe_mem_flush = 1'b1;
                  wd_d               = wd_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC did not advance
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!ctrl.pc_en && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   // State, watchdog and debug registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         wd_q           <= '0;
         stall_cycles_q <= '0;
         md_timeout_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         wd_q           <= wd_d;
         stall_cycles_q <= stall_cycles_d;
         md_timeout_q   <= md_timeout_d;
      end
   end

   assign md_go_o         = ctrl.md_go;
   assign pc_en_o         = ctrl.pc_en;
   assign if_id_en_o      = ctrl.if_id_en;
   assign if_id_flush_o   = ctrl.if_id_flush;
   assign id_exe_en_o     = ctrl.id_exe_en;
   assign id_exe_flush_o  = ctrl.id_exe_flush;
   assign exe_mem_en_o    = ctrl.exe_mem_en;
   assign exe_mem_flush_o = ctrl.exe_mem_flush;
   assign stall_cycles_o  = stall_cycles_q;
   assign md_timeout_o    = md_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for the stall/flush sequencer: two instances (long and short watchdog) on shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [4:0] id_rs, id_rt, exe_dst;
   logic       id_uses_rs, id_uses_rt, exe_wen, exe_is_load, exe_is_md, exe_br_taken, md_done;

   logic        a_go, a_pc, a_ifen, a_iffl, a_idxen, a_idxfl, a_exmen, a_exmfl, a_tmo;
   logic        b_go, b_pc, b_ifen, b_iffl, b_idxen, b_idxfl, b_exmen, b_exmfl, b_tmo;
   logic [31:0] a_stall, b_stall;
   logic [7:0]  a_ctrl, b_ctrl;

   int checks = 0;
   int errors = 0;

   // Model state per instance: busy flag, BUSY cycles seen, stall count, timeout flag
   bit          m_busy [2];
   int          m_n    [2];
   logic [31:0] m_stall[2];
   bit          m_tmo  [2];

   always #5 clk_i = ~clk_i;

   pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(32), .MD_MAX_CYCLES(64)) dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .exe_dst_i(exe_dst),
      .exe_wen_i(exe_wen), .exe_is_load_i(exe_is_load), .exe_is_md_i(exe_is_md),
      .exe_br_taken_i(exe_br_taken), .md_done_i(md_done), .md_go_o(a_go), .pc_en_o(a_pc),
      .if_id_en_o(a_ifen), .if_id_flush_o(a_iffl), .id_exe_en_o(a_idxen),
      .id_exe_flush_o(a_idxfl), .exe_mem_en_o(a_exmen), .exe_mem_flush_o(a_exmfl),
      .stall_cycles_o(a_stall), .md_timeout_o(a_tmo));

   pipe_hazard_ctrl #(.ADDR_W(5), .CNT_W(32), .MD_MAX_CYCLES(4)) dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .exe_dst_i(exe_dst),
      .exe_wen_i(exe_wen), .exe_is_load_i(exe_is_load), .exe_is_md_i(exe_is_md),
      .exe_br_taken_i(exe_br_taken), .md_done_i(md_done), .md_go_o(b_go), .pc_en_o(b_pc),
      .if_id_en_o(b_ifen), .if_id_flush_o(b_iffl), .id_exe_en_o(b_idxen),
      .id_exe_flush_o(b_idxfl), .exe_mem_en_o(b_exmen), .exe_mem_flush_o(b_exmfl),
      .stall_cycles_o(b_stall), .md_timeout_o(b_tmo));

   assign a_ctrl = {a_go, a_pc, a_ifen, a_iffl, a_idxen, a_idxfl, a_exmen, a_exmfl};
   assign b_ctrl = {b_go, b_pc, b_ifen, b_iffl, b_idxen, b_idxfl, b_exmen, b_exmfl};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int max_cycles(input int k);
      return (k == 0) ? 64 : 4;
   endfunction

   // Expected control vector {go,pc,ifen,iffl,idxen,idxfl,exmen,exmfl} from the hazard rules
   function automatic logic [7:0] model_ctrl(input int k);
      bit haz;
      haz = exe_is_load && exe_wen && (exe_dst != 5'd0) &&
            ((id_uses_rs && id_rs == exe_dst) || (id_uses_rt && id_rt == exe_dst));
      if (!rst_ni)     return 8'b0001_0101;
      if (m_busy[k]) begin
         if (md_done || m_n[k] == max_cycles(k) - 1) return 8'b0110_1010;
         return 8'b0000_0011;
      end
      if (exe_is_md)    return 8'b1000_0011;
      if (exe_br_taken) return 8'b0111_1110;
      if (haz)          return 8'b0000_1110;
      return 8'b0110_1010;
   endfunction

   // Every cycle: compare both instances against the model, then advance the model
   always @(negedge clk_i) begin
      for (int k = 0; k < 2; k++) begin
         logic [7:0]  e;
         logic [7:0]  act_c;
         logic [31:0] act_s;
         logic        act_t;
         e     = model_ctrl(k);
         act_c = (k == 0) ? a_ctrl : b_ctrl;
         act_s = (k == 0) ? a_stall : b_stall;
         act_t = (k == 0) ? a_tmo : b_tmo;
         chk(k == 0 ? "model_ctrl_a" : "model_ctrl_b", {24'd0, act_c}, {24'd0, e});
         chk(k == 0 ? "model_stall_a" : "model_stall_b", act_s, rst_ni ? m_stall[k] : 32'd0);
         chk(k == 0 ? "model_tmo_a" : "model_tmo_b", {31'd0, act_t},
             {31'd0, rst_ni ? m_tmo[k] : 1'b0});
         if (!rst_ni) begin
            m_busy[k] = 0; m_n[k] = 0; m_stall[k] = 0; m_tmo[k] = 0;
         end else begin
            if (!e[6] && m_stall[k] != 32'hFFFF_FFFF) m_stall[k] = m_stall[k] + 1;
            if (m_busy[k]) begin
               if (md_done) begin
                  m_busy[k] = 0;
               end else if (m_n[k] == max_cycles(k) - 1) begin
                  m_busy[k] = 0; m_tmo[k] = 1;
               end else begin
                  m_n[k]++;
               end
            end else if (exe_is_md) begin
               m_busy[k] = 1; m_n[k] = 0;
            end
         end
      end
   end

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; exe_dst = 0; exe_wen = 0;
      exe_is_load = 0; exe_is_md = 0; exe_br_taken = 0; md_done = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_load_use(input logic [4:0] dst);
      exe_is_load = 1; exe_wen = 1; exe_dst = dst; id_rs = dst; id_uses_rs = 1;
   endtask

   initial begin
      logic [31:0] s0;
      int go_cnt, stall_n;
      rst_ni = 1'b0;
      clear_inputs();

      // Reset held 5 cycles
      repeat (5) begin
         @(negedge clk_i);
         chk("reset_ctrl", {24'd0, a_ctrl}, 32'h15);
      end
      chk("reset_stall", a_stall, 32'd0);
      next_cycle(); rst_ni = 1'b1;
      @(negedge clk_i);
      chk("run_ctrl", {24'd0, a_ctrl}, 32'h6A);

      // Load-use on rs=5
      next_cycle(); set_load_use(5'd5);
      @(negedge clk_i);
      chk("lu_pc_en", {31'd0, a_pc}, 32'd0);
      chk("lu_idx_flush", {31'd0, a_idxfl}, 32'd1);
      s0 = a_stall;
      next_cycle(); clear_inputs();
      @(negedge clk_i);
      chk("lu_one_cycle", {31'd0, a_pc}, 32'd1);
      chk("lu_stall_cnt", a_stall, s0 + 32'd1);

      // Same pattern against r0: no stall
      next_cycle(); set_load_use(5'd0);
      @(negedge clk_i);
      chk("lu_r0_ctrl", {24'd0, a_ctrl}, 32'h6A);

      // Branch together with a load-use hazard
      next_cycle(); clear_inputs(); set_load_use(5'd5); exe_br_taken = 1;
      @(negedge clk_i);
      chk("br_lu_ctrl", {24'd0, a_ctrl}, 32'h7E);
      s0 = a_stall;
      next_cycle(); clear_inputs();
      @(negedge clk_i);
      chk("br_lu_stall", a_stall, s0);

      // Mul/div with done on the 9th BUSY cycle
      s0 = a_stall; go_cnt = 0; stall_n = 0;
      for (int c = 0; c < 10; c++) begin
         next_cycle(); exe_is_md = 1; md_done = (c == 9);
         @(negedge clk_i);
         go_cnt += int'(a_go);
         if (!a_pc) stall_n++;
         if (c == 9) chk("md_release", {24'd0, a_ctrl}, 32'h6A);
      end
      next_cycle(); clear_inputs();
      @(negedge clk_i);
      chk("md_go_pulses", go_cnt, 32'd1);
      chk("md_stall_len", stall_n, 32'd9);
      chk("md_stall_cnt", a_stall - s0, 32'd9);
      chk("md_no_rego", {31'd0, a_go}, 32'd0);

      // Watchdog on the short instance
      next_cycle(); rst_ni = 1'b0;
      next_cycle(); rst_ni = 1'b1;
      for (int c = 0; c < 6; c++) begin
         next_cycle(); exe_is_md = (c < 5);
         @(negedge clk_i);
         if (c < 5) chk("wd_pc_en", {31'd0, b_pc}, (c == 4) ? 32'd1 : 32'd0);
         if (c == 4) chk("wd_tmo_pre", {31'd0, b_tmo}, 32'd0);
         if (c == 5) chk("wd_tmo_set", {31'd0, b_tmo}, 32'd1);
      end
      repeat (3) next_cycle();
      @(negedge clk_i);
      chk("wd_tmo_sticky", {31'd0, b_tmo}, 32'd1);
      next_cycle(); md_done = 1;
      next_cycle(); md_done = 0;

      // Reset during the 3rd BUSY cycle
      for (int c = 0; c < 3; c++) begin
         next_cycle(); exe_is_md = 1;
      end
      next_cycle(); rst_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_busy_a", {24'd0, a_ctrl}, 32'h15);
      chk("rst_busy_tmo", {31'd0, b_tmo}, 32'd0);
      next_cycle(); rst_ni = 1'b1; exe_is_md = 0;
      @(negedge clk_i);
      chk("rst_busy_idle", {24'd0, a_ctrl}, 32'h6A);

      // Randomized traffic with small register indices to provoke collisions
      repeat (3000) begin
         next_cycle();
         rst_ni       = ($urandom_range(0, 149) != 0);
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         exe_dst      = 5'($urandom_range(0, 3));
         id_uses_rs   = 1'($urandom_range(0, 1));
         id_uses_rt   = 1'($urandom_range(0, 1));
         exe_wen      = ($urandom_range(0, 3) != 0);
         exe_is_load  = 1'($urandom_range(0, 1));
         exe_is_md    = ($urandom_range(0, 9) == 0);
         exe_br_taken = ($urandom_range(0, 4) == 0);
         md_done      = ($urandom_range(0, 7) == 0);
      end
      next_cycle(); clear_inputs();
      @(negedge clk_i);
      @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
